// File: rtl/hamming_decoder.sv
// (12,8) Hamming SEC decoder: two-stage valid/ready pipeline (syndrome capture, then correction)
// with saturating corrected/uncorrectable word counters.
module hamming_decoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [11:0]      code_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       data_out,
    output logic [3:0]       syndrome,
    output logic             err_corr,
    output logic             err_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic             s1_valid_q;
    logic [11:0]      s1_code_q;
    logic [3:0]       s1_syn_q;
    logic             s2_valid_q;
    logic [7:0]       s2_data_q;
    logic [3:0]       s2_syn_q;
    logic             s2_corr_q;
    logic             s2_uncorr_q;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    logic        s2_free;
    logic        s1_adv;
    logic        s1_load;
    logic        out_xfer;
    logic [3:0]  syn_in;
    logic [11:0] flip_mask;
    logic [11:0] fixed_code;
    logic [7:0]  fixed_data;
    logic        syn_corr;
    logic        syn_uncorr;

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign s1_load  = in_valid && in_ready;
    assign out_xfer = s2_valid_q && out_ready;

    assign syn_in[0] = ^{code_in[0], code_in[2], code_in[4], code_in[6], code_in[8], code_in[10]};
    assign syn_in[1] = ^{code_in[1], code_in[2], code_in[5], code_in[6], code_in[9], code_in[10]};
    assign syn_in[2] = ^{code_in[3], code_in[4], code_in[5], code_in[6], code_in[11]};
    assign syn_in[3] = ^code_in[11:7];

    // Syndromes 13..15 match no bit position, so the mask stays zero and the raw data passes.
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < 12; i++) begin
            flip_mask[i] = (s1_syn_q == 4'(i + 1));
        end
    end

    assign fixed_code = s1_code_q ^ flip_mask;
    assign fixed_data = {fixed_code[11:8], fixed_code[6:4], fixed_code[2]};
    assign syn_corr   = (s1_syn_q != 4'd0) && (s1_syn_q <= 4'd12);
    assign syn_uncorr = (s1_syn_q >= 4'd13);

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
            s1_code_q  <= code_in;
            s1_syn_q   <= syn_in;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_syn_q    <= '0;
            s2_corr_q   <= 1'b0;
            s2_uncorr_q <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q  <= 1'b1;
            s2_data_q   <= fixed_data;
            s2_syn_q    <= s1_syn_q;
            s2_corr_q   <= syn_corr;
            s2_uncorr_q <= syn_uncorr;
        end else if (out_xfer) begin
            s2_valid_q <= 1'b0;
        end
    end

    // Clear wins over a simultaneous transfer.
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (out_xfer) begin
            if (s2_corr_q && corr_cnt_q != CntMax) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if (s2_uncorr_q && uncorr_cnt_q != CntMax) begin
                uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign data_out   = s2_data_q;
    assign syndrome   = s2_syn_q;
    assign err_corr   = s2_corr_q;
    assign err_uncorr = s2_uncorr_q;
    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: directed codewords plus a random valid/ready stream, checked against
// a position-XOR reference decoder and a queue of expected outputs.
module tb_hamming_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] code_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  data_out;
    logic [3:0]  syndrome;
    logic        err_corr;
    logic        err_uncorr;
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  data_out2;
    logic [3:0]  syndrome2;
    logic        err_corr2;
    logic        err_uncorr2;
    logic [1:0]  corr_cnt2;
    logic [1:0]  uncorr_cnt2;

    always #5 clk = ~clk;

    hamming_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .syndrome(syndrome),
        .err_corr(err_corr), .err_uncorr(err_uncorr), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    // Narrow-counter instance sees the same traffic, to exercise saturation.
    hamming_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .code_in(code_in),
        .out_valid(out_valid2), .out_ready(out_ready), .data_out(data_out2),
        .syndrome(syndrome2), .err_corr(err_corr2), .err_uncorr(err_uncorr2), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] syn;
        logic       corr;
        logic       unc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned m_corr, m_unc, m_corr2, m_unc2;
    logic        held_valid;
    logic [13:0] held;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Syndrome = XOR of the 1-based positions of all set bits.
    function automatic exp_t model_decode(input logic [11:0] code);
        exp_t        e;
        int          s;
        logic [11:0] c;
        int          dpos[8] = '{2, 4, 5, 6, 8, 9, 10, 11};
        s = 0;
        c = code;
        for (int i = 0; i < 12; i++) if (code[i]) s = s ^ (i + 1);
        e.syn  = 4'(s);
        e.corr = (s >= 1 && s <= 12);
        e.unc  = (s >= 13);
        if (e.corr) c[s-1] = ~c[s-1];
        for (int k = 0; k < 8; k++) e.data[k] = c[dpos[k]];
        return e;
    endfunction

    function automatic logic [11:0] encode(input logic [7:0] d);
        logic [11:0] c;
        int          s;
        int          dpos[8] = '{2, 4, 5, 6, 8, 9, 10, 11};
        c = '0;
        s = 0;
        for (int k = 0; k < 8; k++) c[dpos[k]] = d[k];
        for (int i = 0; i < 12; i++) if (c[i]) s = s ^ (i + 1);
        c[0] = s[0];
        c[1] = s[1];
        c[3] = s[2];
        c[7] = s[3];
        return c;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return (v < max) ? v + 1 : v;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
        held_valid = 1'b0;
        held = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; code_in = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_outputs"}, {data_out, syndrome, err_corr, err_uncorr}, 0);
        check_eq({tag, "_cnts"}, {corr_cnt, uncorr_cnt}, 0);
        check_eq({tag, "_cnts2"}, {corr_cnt2, uncorr_cnt2}, 0);
    endtask

    // One clock: drive, check at the falling edge, update the model for the coming rising edge.
    task automatic cycle(input logic iv, input logic [11:0] code, input logic ordy,
                         input logic clr, output logic acc);
        exp_t e;
        in_valid = iv; code_in = code; out_ready = ordy; cnt_clr = clr;
        @(negedge clk);
        check_eq("corr_cnt", corr_cnt, m_corr);
        check_eq("uncorr_cnt", uncorr_cnt, m_unc);
        check_eq("corr_cnt2", corr_cnt2, m_corr2);
        check_eq("uncorr_cnt2", uncorr_cnt2, m_unc2);
        check_eq("in_ready", in_ready, (exp_q.size() < 2) || ordy);
        if (held_valid) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_hold", {data_out, syndrome, err_corr, err_uncorr}, held);
        end
        if (exp_q.size() == 0) check_eq("spurious_out", out_valid, 0);
        if (out_valid && ordy && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("decode", {data_out, syndrome, err_corr, err_uncorr}, e);
            if (e.corr) begin m_corr = sat_inc(m_corr, 65535); m_corr2 = sat_inc(m_corr2, 3); end
            if (e.unc)  begin m_unc = sat_inc(m_unc, 65535);   m_unc2 = sat_inc(m_unc2, 3);   end
        end
        if (clr) begin
            m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
        end
        acc = iv && in_ready;
        if (acc) exp_q.push_back(model_decode(code));
        held_valid = out_valid && !ordy;
        held = {data_out, syndrome, err_corr, err_uncorr};
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [11:0] code, input logic [7:0] ed,
                            input logic [3:0] es, input logic ec, input logic eu);
        logic acc;
        cycle(1'b1, code, 1'b1, 1'b0, acc);
        check_eq({tag, "_accept"}, acc, 1);
        check_eq({tag, "_lat1"}, out_valid, 0);
        cycle(1'b0, 12'h000, 1'b1, 1'b0, acc);
        check_eq({tag, "_lat2"}, out_valid, 1);
        check_eq({tag, "_data"}, data_out, ed);
        check_eq({tag, "_syn"}, syndrome, es);
        check_eq({tag, "_flags"}, {err_corr, err_uncorr}, {ec, eu});
        cycle(1'b0, 12'h000, 1'b1, 1'b0, acc);
    endtask

    initial begin
        logic        acc;
        logic [11:0] code;
        int          sent;
        int          cyc;

        do_reset();
        do_reset();
        check_reset("reset");

        directed("t1", 12'hA27, 8'hA5, 4'd0, 1'b0, 1'b0);
        check_eq("t1_cnts", {corr_cnt, uncorr_cnt}, 0);
        directed("t2", 12'hA07, 8'hA5, 4'd6, 1'b1, 1'b0);
        check_eq("t2_corr_cnt", corr_cnt, 1);
        directed("t3", 12'hAA7, 8'hA5, 4'd8, 1'b1, 1'b0);
        directed("t4", 12'h225, 8'h25, 4'd14, 1'b0, 1'b1);
        check_eq("t4_uncorr_cnt", uncorr_cnt, 1);

        // Saturation of the 2-bit counter, then clear colliding with a transfer.
        cycle(1'b0, 12'h000, 1'b1, 1'b1, acc);
        for (int i = 0; i < 5; i++) directed("t6_sat", 12'hA07, 8'hA5, 4'd6, 1'b1, 1'b0);
        check_eq("t6_corr_cnt2_sat", corr_cnt2, 3);
        check_eq("t6_corr_cnt_wide", corr_cnt, 5);
        cycle(1'b1, 12'hA07, 1'b1, 1'b0, acc);
        cycle(1'b0, 12'h000, 1'b1, 1'b0, acc);
        check_eq("t6_pre_clr_valid", out_valid, 1);
        cycle(1'b0, 12'h000, 1'b1, 1'b1, acc);
        check_eq("t6_clr_xfer", corr_cnt, 0);
        check_eq("t6_clr_xfer2", corr_cnt2, 0);

        // Random stream with 0, 1 or 2 bit flips and random back-pressure.
        sent = 0;
        cyc = 0;
        code = encode(8'($urandom));
        while ((sent < 20 || exp_q.size() > 0) && cyc < 1000) begin
            cycle((sent < 20) && ($urandom_range(0, 3) != 0), code,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0, acc);
            if (acc) begin
                sent++;
                code = encode(8'($urandom));
                for (int f = $urandom_range(0, 2); f > 0; f--) begin
                    code[$urandom_range(0, 11)] ^= 1'b1;
                end
            end
            cyc++;
        end
        check_eq("t5_sent", sent, 20);
        check_eq("t5_drained", exp_q.size(), 0);

        // Fill both stages under back-pressure, then reset.
        cycle(1'b1, 12'hA07, 1'b0, 1'b0, acc);
        cycle(1'b1, 12'h225, 1'b0, 1'b0, acc);
        check_eq("t6_full_valid", out_valid, 1);
        check_eq("t6_full_ready", in_ready, 0);
        do_reset();
        check_reset("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
